fp_mant_div_seq: RTL and testbench

// - Iterative radix-2 restoring divider for single-precision FP divide mantissas; one quotient bit per clock.
// - Sits directly upstream of the leading-one counter (N=26): its quot bus drives the counter's in[25:0].
// - The counter's shift_count steers the normaliser; sticky feeds rounding.
// - Operands carry the hidden bit, so a,b are in [1,2), quot is in (0.5,2) and the leading 1 is at bit 25 or 24.

---
 rtl/fp_div_pkg.sv | 27 ++
 rtl/fp_div_step.sv | 33 +++
 rtl/fp_mant_div_seq.sv | 141 ++++++++++++++
 tb/tb_fp_mant_div_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_pkg
// Purpose  : Shared widths, state encoding and constants for the FP mantissa
//            divide path. The leading-one counter (N=QW) and the normaliser
//            import this package too.
// Revision : 1.0 - initial release
// ============================================================================
package fp_div_pkg;

  // Mantissa width including the hidden bit.
  localparam int MW = 24;
  // Quotient width: 1 integer bit plus MW+1 fraction bits (guard, round).
  localparam int QW = MW + 2;
  // Iteration counter width. It must be able to hold the value QW.
  localparam int CW = $clog2(QW + 1);

  // Divider FSM state encoding.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Quotient reported for a divide by zero.
  localparam logic [QW-1:0] QUOT_DZ = {QW{1'b1}};

endpackage : fp_div_pkg
`default_nettype wire

// File: rtl/fp_div_step.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_step
// Purpose  : One restoring-division step. The partial remainder is doubled
//            (except on the first step), compared against the divisor, and
//            the divisor is subtracted when it fits.
// Revision : 1.0 - initial release
// ============================================================================
module fp_div_step
  import fp_div_pkg::*;
(
  input  logic [MW:0]   r_i,
  input  logic [MW-1:0] b_i,
  input  logic          first_i,
  output logic [MW:0]   r_next_o,
  output logic          q_bit_o
);

  logic [MW:0] r_shift;
  logic [MW:0] b_ext;

  assign b_ext = {1'b0, b_i};

  // Doubling never overflows: after every step R < B < 2^MW, so 2R < 2^(MW+1).
  // The first step compares the raw dividend, which yields the integer bit.
  always_comb begin
    r_shift  = first_i ? r_i : {r_i[MW-1:0], 1'b0};
    q_bit_o  = (r_shift >= b_ext);
    r_next_o = q_bit_o ? (r_shift - b_ext) : r_shift;
  end

endmodule : fp_div_step
`default_nettype wire

// File: rtl/fp_mant_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_mant_div_seq
// Purpose  : Iterative radix-2 restoring divider for single-precision
//            mantissas, one quotient bit per clock. quot = floor(a/b*2^(QW-1)),
//            sticky flags a non-zero final remainder, dz flags b == 0.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mant_div_seq
  import fp_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] mant_a,
  input  logic [MW-1:0] mant_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quot,
  output logic          sticky,
  output logic          dz
);

  logic [1:0]    state_q, state_d;
  logic          out_valid_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW:0]   rem_q, rem_d;
  logic [MW-1:0] div_q, div_d;
  logic [QW-1:0] quot_q, quot_d;
  logic          sticky_q, sticky_d;
  logic          dz_q, dz_d;

  logic [MW:0]   step_rem;
  logic          step_bit;
  logic          last_step;

  assign last_step = (cnt_q == CW'(QW - 1));

  fp_div_step u_step (
    .r_i      (rem_q),
    .b_i      (div_q),
    .first_i  (cnt_q == '0),
    .r_next_o (step_rem),
    .q_bit_o  (step_bit)
  );

  // FSM state register; out_valid is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == DONE);
    end
  end

  // FSM next state; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = DIV;
      DIV:     if (dz_q || last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // FSM outputs: operands are accepted only in IDLE.
  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // Datapath next state: operand load, iteration, and result finalisation.
  // Nothing changes on flush, so the last quot/sticky/dz stay visible.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quot_d   = quot_q;
    sticky_d = sticky_q;
    dz_d     = dz_q;
    if (!flush) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rem_d = {1'b0, mant_a};
            div_d = mant_b;
            cnt_d = '0;
            dz_d  = (mant_b == '0);
          end
        end
        DIV: begin
          if (dz_q) begin
            quot_d   = QUOT_DZ;
            sticky_d = 1'b1;
          end else begin
            rem_d  = step_rem;
            quot_d = {quot_q[QW-2:0], step_bit};
            cnt_d  = cnt_q + CW'(1);
            if (last_step) begin
              sticky_d = |step_rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quot_q   <= '0;
      sticky_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quot_q   <= quot_d;
      sticky_q <= sticky_d;
      dz_q     <= dz_d;
    end
  end

  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign sticky    = sticky_q;
  assign dz        = dz_q;

endmodule : fp_mant_div_seq
`default_nettype wire

// File: tb/tb_fp_mant_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mant_div_seq
// Purpose  : Self-checking bench for fp_mant_div_seq with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mant_div_seq;
  import fp_div_pkg::*;

  typedef struct packed {
    logic [QW-1:0] quot;
    logic          sticky;
    logic          dz;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] mant_a;
  logic [MW-1:0] mant_b;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quot;
  logic          sticky;
  logic          dz;

  exp_t sb_q[$];
  int   n_chk;
  int   n_fail;

  fp_mant_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_a    (mant_a),
    .mant_b    (mant_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .sticky    (sticky),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: floor(a * 2^(QW-1) / b) and its remainder.
  function automatic exp_t model(input logic [MW-1:0] a, input logic [MW-1:0] b);
    exp_t        e;
    logic [63:0] num;
    if (b == '0) begin
      e.quot   = 26'h3FFFFFF;
      e.sticky = 1'b1;
      e.dz     = 1'b1;
    end else begin
      num      = {40'd0, a} << (QW - 1);
      e.quot   = QW'(num / {40'd0, b});
      e.sticky = ((num % {40'd0, b}) != 64'd0);
      e.dz     = 1'b0;
    end
    return e;
  endfunction

  task automatic run_op(input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input int lat, input int hold);
    exp_t e;
    int   cyc;
    chk("in_ready_idle", in_ready, 1);
    mant_a   = a;
    mant_b   = b;
    in_valid = 1'b1;
    sb_q.push_back(model(a, b));
    tick();
    in_valid = 1'b0;
    mant_a   = MW'($urandom);
    mant_b   = MW'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("latency", cyc, lat);
    e = sb_q.pop_front();
    if (!out_valid) return;
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_quot", quot, e.quot);
      chk("hold_in_ready", in_ready, 0);
    end
    chk("quot", quot, e.quot);
    chk("sticky", sticky, e.sticky);
    chk("dz", dz, e.dz);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_clr", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int seen;
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_a    = '0;
    mant_b    = '0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_quot", quot, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_dz", dz, 0);
    rst_n = 1'b1;
    tick();

    // Directed values with hand-derived results.
    run_op(24'h800000, 24'h800000, 27, 0);
    run_op(24'hC00000, 24'h800000, 27, 0);
    run_op(24'h800000, 24'hC00000, 27, 0);
    run_op(24'hFFFFFF, 24'h800000, 27, 0);
    run_op(24'h800000, 24'hFFFFFF, 27, 0);
    run_op(24'hABCDEF, 24'h000000, 2, 0);
    // Back-pressure: result held for 5 cycles.
    run_op(24'h800000, 24'hC00000, 27, 5);
    // A normal op directly after divide-by-zero clears dz.
    run_op(24'hFFFFFF, 24'hFFFFFF, 27, 0);

    // Random normalised operands.
    for (int i = 0; i < 8; i++) begin
      run_op(MW'($urandom) | 24'h800000, MW'($urandom) | 24'h800000, 27,
             int'($urandom_range(0, 2)));
    end

    // Flush at DIV step 10: back to IDLE, no result emitted.
    mant_a   = 24'h900000;
    mant_b   = 24'hA00000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("flush_no_valid", seen, 0);
    run_op(24'hC00000, 24'h800000, 27, 0);

    // Asynchronous reset mid-DIV.
    mant_a   = 24'hC00000;
    mant_b   = 24'h900000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_quot", quot, 0);
    chk("arst_sticky", sticky, 0);
    chk("arst_dz", dz, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst_no_valid", seen, 0);
    run_op(24'h800000, 24'h800000, 27, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fp_mant_div_seq
`default_nettype wire
